// File: rtl/cla_slice_seq_adder.sv
// Sequential WIDTH-bit add/subtract built from one shared 4-bit carry-lookahead
// slice, processed least-significant nibble first over NSLICE cycles.

module cla_unit4 (
   input  logic [3:0] g,
   input  logic [3:0] p,
   input  logic       c0,
   output logic [4:0] c
);

   // Two-level lookahead: every carry is a direct function of g, p and c0.
   always_comb begin
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
   end

endmodule

module cla_slice_seq_adder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             zero,
   output logic             busy
);

   localparam int NSLICE = WIDTH / 4;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   sum_q;
   logic [WIDTH-1:0]   sum_next;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q;
   logic               cout_q;
   logic               overflow_q;
   logic               zero_q;
   logic               last_slice;
   logic [3:0]         slice_g;
   logic [3:0]         slice_p;
   logic [3:0]         slice_sum;
   logic [4:0]         slice_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)   state_d = RUN;
         RUN:     if (last_slice) state_d = DONE;
         DONE:    if (out_ready)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operands shift down one nibble per cycle so the active slice is always
   // bits [3:0]; the sum fills from the top and lands aligned after NSLICE steps.
   assign slice_g = a_q[3:0] & b_q[3:0];
   assign slice_p = a_q[3:0] ^ b_q[3:0];

   cla_unit4 u_cla (
      .g  (slice_g),
      .p  (slice_p),
      .c0 (carry_q),
      .c  (slice_c)
   );

   assign slice_sum = slice_p ^ slice_c[3:0];

   always_comb begin
      sum_next                = sum_q >> 4;
      sum_next[WIDTH-1 -: 4]  = slice_sum;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         sum_q      <= '0;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         cout_q     <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub;
                  idx_q   <= '0;
               end
            end
            RUN: begin
               a_q     <= a_q >> 4;
               b_q     <= b_q >> 4;
               sum_q   <= sum_next;
               carry_q <= slice_c[4];
               if (last_slice) begin
                  cout_q     <= slice_c[4];
                  overflow_q <= slice_c[3] ^ slice_c[4];
                  zero_q     <= (sum_next == '0);
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign overflow  = overflow_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_cla_slice_seq_adder.sv
// Randomized and directed bench for cla_slice_seq_adder; a negedge monitor
// scores every handshake against an arithmetic reference model.

module tb_cla_slice_seq_adder;

   localparam int WIDTH  = 32;
   localparam int NSLICE = WIDTH / 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              sub;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  sum;
   logic              cout;
   logic              overflow;
   logic              zero;
   logic              busy;

   int                checks      = 0;
   int                failures    = 0;
   int                cycleCnt    = 0;
   int                consumed    = 0;
   int                acceptCyc   = 0;
   bit                awaitFirst  = 1'b0;
   bit                heldValid   = 1'b0;
   logic [34:0]       heldVal;
   logic [34:0]       expQ[$];
   int                acceptLog[$];

   logic [31:0] dirA[4]   = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000};
   logic [31:0] dirB[4]   = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001};
   logic        dirSub[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   logic [34:0] dirExp[4] = '{{3'b101, 32'h0000_0000}, {3'b010, 32'h8000_0000},
                              {3'b000, 32'hFFFF_FFFE}, {3'b110, 32'h7FFF_FFFF}};

   cla_slice_seq_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow),
      .zero      (zero),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Result as {cout, overflow, zero, sum}, from ordinary add/subtract semantics.
   function automatic logic [34:0] refModel(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
      logic [32:0] wide;
      logic [31:0] r;
      logic        c;
      logic        v;
      if (!s) begin
         wide = {1'b0, x} + {1'b0, y};
         r    = wide[31:0];
         c    = wide[32];
         v    = (x[31] == y[31]) && (r[31] != x[31]);
      end else begin
         r = x - y;
         c = (x >= y);
         v = (x[31] != y[31]) && (r[31] != x[31]);
      end
      return {c, v, (r == 32'h0), r};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Monitor: scoreboard, latency, stability while stalled, no accept in DONE.
   always @(negedge clk) begin
      if (rst) begin
         expQ.delete();
         awaitFirst = 1'b0;
         heldValid  = 1'b0;
      end else begin
         if (heldValid && out_valid)
            checkOutput("stable_while_stalled", {cout, overflow, zero, sum}, heldVal);
         if (out_valid) begin
            checkOutput("in_ready_in_done", in_ready, 0);
            if (expQ.size() == 0) begin
               checkOutput("spurious_out_valid", out_valid, 0);
            end else if (awaitFirst) begin
               checkOutput("latency", 64'(cycleCnt - acceptCyc), NSLICE);
               awaitFirst = 1'b0;
            end
         end
         if (out_valid && out_ready) begin
            if (expQ.size() > 0)
               checkOutput("result", {cout, overflow, zero, sum}, expQ.pop_front());
            consumed++;
            heldValid = 1'b0;
         end else begin
            heldValid = out_valid;
            heldVal   = {cout, overflow, zero, sum};
         end
         if (in_valid && in_ready) begin
            expQ.push_back(refModel(a, b, sub));
            acceptCyc  = cycleCnt + 1;
            awaitFirst = 1'b1;
            acceptLog.push_back(cycleCnt + 1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble();
      a   = $urandom;
      b   = $urandom;
      sub = 1'($urandom_range(0, 1));
   endtask

   task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic s);
      int n = 0;
      a        = x;
      b        = y;
      sub      = s;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) checkOutput("accept_timeout", 0, 1);
      tick();
      in_valid = 1'b0;
      scramble();
   endtask

   task automatic waitValid();
      int n = 0;
      while (!out_valid && n < 50) begin
         checkOutput("busy_in_run", busy, 1);
         checkOutput("in_ready_in_run", in_ready, 0);
         scramble();
         tick();
         n++;
      end
      if (!out_valid) checkOutput("result_timeout", 0, 1);
   endtask

   task automatic waitResult(input int hold, output logic [34:0] res);
      waitValid();
      repeat (hold) tick();
      res       = {cout, overflow, zero, sum};
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      logic [34:0] res;
      logic [31:0] x1, y1, x2, y2;
      logic        s1, s2;
      int          c0;
      int          n0;
      int          n;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      sub       = 1'b0;
      repeat (3) tick();
      checkOutput("reset_handshake", {in_ready, out_valid, busy}, 3'b100);
      checkOutput("reset_result", {cout, overflow, zero, sum}, 35'h0);
      rst = 1'b0;
      tick();

      $display("[TB] directed vectors");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(dirA[i], dirB[i], dirSub[i]);
         waitResult(i % 2, res);
         checkOutput($sformatf("directed_%0d", i), res, dirExp[i]);
      end

      $display("[TB] backpressure with a pending request");
      x1 = $urandom; y1 = $urandom; s1 = 1'($urandom_range(0, 1));
      x2 = $urandom; y2 = $urandom; s2 = 1'($urandom_range(0, 1));
      applyStimulus(x1, y1, s1);
      waitValid();
      c0       = consumed;
      a        = x2;
      b        = y2;
      sub      = s2;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checkOutput("in_ready_backpressure", in_ready, 0);
         tick();
      end
      checkOutput("bp_first_result", {cout, overflow, zero, sum}, refModel(x1, y1, s1));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("in_ready_after_consume", in_ready, 1);
      tick();
      in_valid = 1'b0;
      checkOutput("one_result_consumed", 64'(consumed - c0), 1);
      checkOutput("second_accepted", busy, 1);
      waitResult(0, res);
      checkOutput("bp_second_result", res, refModel(x2, y2, s2));

      $display("[TB] streaming initiation interval");
      n0        = acceptLog.size();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      n         = 0;
      while (acceptLog.size() < n0 + 4 && n < 200) begin
         scramble();
         tick();
         n++;
      end
      in_valid = 1'b0;
      if (acceptLog.size() < n0 + 4) begin
         checkOutput("stream_timeout", 0, 1);
      end else begin
         for (int i = 0; i < 3; i++)
            checkOutput("initiation_interval", 64'(acceptLog[n0+i+1] - acceptLog[n0+i]), NSLICE + 2);
      end
      n = 0;
      while (expQ.size() > 0 && n < 50) begin
         tick();
         n++;
      end
      out_ready = 1'b0;
      tick();

      $display("[TB] reset during RUN");
      applyStimulus($urandom, $urandom, 1'b0);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("abort_handshake", {in_ready, out_valid, busy}, 3'b100);
      checkOutput("abort_result", {cout, overflow, zero, sum}, 35'h0);
      repeat (12) tick();
      checkOutput("no_aborted_result", out_valid, 0);
      applyStimulus(32'h1, 32'h2, 1'b0);
      waitResult(0, res);
      checkOutput("after_abort_add", res, {3'b000, 32'h3});

      $display("[TB] random operations");
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0:       applyStimulus(32'hFFFF_FFFF, $urandom, 1'($urandom_range(0, 1)));
            1:       applyStimulus($urandom, $urandom & 32'h8000_000F, 1'($urandom_range(0, 1)));
            default: applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)));
         endcase
         waitResult($urandom_range(0, 2), res);
      end
      repeat (3) tick();
      checkOutput("scoreboard_drained", 64'(expQ.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
